// File: rtl/ccl_pkg.sv
// Shared constants and FSM state type for the code-length symbol decoder.
// CCL_DEC_ERR_EN adds the sticky ERR state.
package ccl_pkg;

  localparam int MAX_LEN = 4;
  localparam int NSYM = 10;
  localparam int TBL_DEPTH = 16;
  localparam logic [3:0] SYM_INVALID = 4'hF;

`ifdef CCL_DEC_ERR_EN
  typedef enum logic [1:0] {
    IDLE, DECODE, EMIT, ERR
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DECODE, EMIT
  } state_t;
`endif

endpackage

// File: rtl/ccl_dec_ctr.sv
// Decoder control FSM: bit/symbol handshakes and state sequencing.
// CCL_DEC_ERR_EN enables the sticky error state.
module ccl_dec_ctr
  import ccl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tbl_rdy_i,
  input  logic bit_valid_i,
  input  logic sym_ready_i,
  input  logic hit_i,
  input  logic full_i,
  output logic bit_ready_o,
  output logic sym_valid_o,
  output logic err_o,
  output logic dec_o
);

  state_t state_q;
  logic   bit_ready_q;
  logic   sym_valid_q;
  logic   fire;
`ifdef CCL_DEC_ERR_EN
  logic   err_q;
`endif

  assign fire  = bit_valid_i & bit_ready_q;
  assign dec_o = (state_q == DECODE) & tbl_rdy_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_ready_q <= 1'b0;
      sym_valid_q <= 1'b0;
`ifdef CCL_DEC_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tbl_rdy_i) begin
            state_q     <= DECODE;
            bit_ready_q <= 1'b1;
          end
        end
        DECODE: begin
          // table loss wins over a bit arriving on the same edge
          if (!tbl_rdy_i) begin
            state_q     <= IDLE;
            bit_ready_q <= 1'b0;
          end else if (fire && hit_i) begin
            state_q     <= EMIT;
            bit_ready_q <= 1'b0;
            sym_valid_q <= 1'b1;
          end else if (fire && full_i) begin
`ifdef CCL_DEC_ERR_EN
            state_q     <= ERR;
            bit_ready_q <= 1'b0;
            err_q       <= 1'b1;
`else
            state_q     <= DECODE;
`endif
          end
        end
        EMIT: begin
          if (sym_ready_i) begin
            sym_valid_q <= 1'b0;
            state_q     <= tbl_rdy_i ? DECODE : IDLE;
            bit_ready_q <= tbl_rdy_i;
          end
        end
`ifdef CCL_DEC_ERR_EN
        ERR: begin
          state_q <= ERR;
        end
`endif
        default: begin
          state_q     <= IDLE;
          bit_ready_q <= 1'b0;
          sym_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bit_ready_o = bit_ready_q;
  assign sym_valid_o = sym_valid_q;
`ifdef CCL_DEC_ERR_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/ccl_sym_decoder.sv
// Serial canonical-code symbol decoder; datapath here, FSM in ccl_dec_ctr.
// CCL_DEC_ERR_EN turns unmatched codewords into a sticky err.
module ccl_sym_decoder #(
  parameter int MAX_LEN = 4,
  parameter int SYM_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tbl_rdy,
  input  logic [63:0]      ccl_code_sq,
  input  logic [15:0]      ccl_count_sq,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym,
  input  logic             sym_ready,
  output logic             err
);

  import ccl_pkg::*;

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam int CW = $clog2(TBL_DEPTH);

  logic [SYM_W-1:0] cnt_a [MAX_LEN];
  logic [SYM_W-1:0] tbl_a [TBL_DEPTH];

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cnt
    assign cnt_a[i] = ccl_count_sq[i*SYM_W +: SYM_W];
  end
  for (genvar i = 0; i < TBL_DEPTH; i++) begin : g_tbl
    assign tbl_a[i] = ccl_code_sq[i*SYM_W +: SYM_W];
  end

  logic [CW-1:0]    code_q, code_d;
  logic [LW-1:0]    len_q, len_d;
  logic [CW:0]      first_q, first_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CW:0]      code_n, diff;
  logic [SYM_W-1:0] cnt, entry;
  logic             fire, dec, hit, full;

  assign fire = bit_valid & bit_ready;

  // first_q tracks first[L] for the level the next bit completes
  always_comb begin
    code_n  = {code_q, bit_in};
    diff    = code_n - first_q;
    cnt     = cnt_a[len_q[IW-1:0]];
    entry   = tbl_a[code_n[CW-1:0]];
    hit     = fire && (diff < (CW+1)'(cnt))
              && (entry != SYM_W'(SYM_INVALID));
    full    = (len_q == LW'(MAX_LEN - 1));
    code_d  = code_q;
    len_d   = len_q;
    first_d = first_q;
    sym_d   = sym_q;
    if (!dec) begin
      code_d  = '0;
      len_d   = '0;
      first_d = '0;
    end else if (fire) begin
      if (hit || full) begin
        code_d  = '0;
        len_d   = '0;
        first_d = '0;
        if (hit) sym_d = entry;
      end else begin
        code_d  = code_n[CW-1:0];
        len_d   = len_q + 1'b1;
        first_d = (first_q + (CW+1)'(cnt)) << 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q  <= '0;
      len_q   <= '0;
      first_q <= '0;
      sym_q   <= '0;
    end else begin
      code_q  <= code_d;
      len_q   <= len_d;
      first_q <= first_d;
      sym_q   <= sym_d;
    end
  end

  assign sym = sym_q;

  ccl_dec_ctr u_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .tbl_rdy_i   (tbl_rdy),
    .bit_valid_i (bit_valid),
    .sym_ready_i (sym_ready),
    .hit_i       (hit),
    .full_i      (full),
    .bit_ready_o (bit_ready),
    .sym_valid_o (sym_valid),
    .err_o       (err),
    .dec_o       (dec)
  );

endmodule

// File: tb/tb_ccl_sym_decoder.sv
// Directed bench for ccl_sym_decoder; follows CCL_DEC_ERR_EN
// for the invalid-codeword expectations.
module tb_ccl_sym_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_rdy;
  logic [63:0] ccl_code_sq;
  logic [15:0] ccl_count_sq;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [3:0]  sym;
  logic        sym_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ccl_sym_decoder #(.MAX_LEN(4), .SYM_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tbl_rdy      (tbl_rdy),
    .ccl_code_sq  (ccl_code_sq),
    .ccl_count_sq (ccl_count_sq),
    .bit_valid    (bit_valid),
    .bit_in       (bit_in),
    .bit_ready    (bit_ready),
    .sym_valid    (sym_valid),
    .sym          (sym),
    .sym_ready    (sym_ready),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // present one bit, wait (bounded) for bit_ready, consume on posedge
  task automatic send(input logic b);
    int n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (bit_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bit_ready_wait", {31'd0, bit_ready}, 32'd1);
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    tbl_rdy      = 1'b0;
    ccl_count_sq = 16'h0211;
    ccl_code_sq  = 64'hFFFF_FFFF_32FF_F1F0;
    bit_valid    = 1'b0;
    bit_in       = 1'b0;
    sym_ready    = 1'b1;
    tick();
    tick();
    check("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
    check("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    check("rst_sym", {28'd0, sym}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_bit_ready", {31'd0, bit_ready}, 32'd0);
    tbl_rdy = 1'b1;
    tick();
    check("decode_bit_ready", {31'd0, bit_ready}, 32'd1);

    // back-to-back codewords 0 / 10 / 110 / 111
    send(1'b0);
    check("s0_valid", {31'd0, sym_valid}, 32'd1);
    check("s0_sym", {28'd0, sym}, 32'd0);
    send(1'b1);
    check("s1_mid_valid", {31'd0, sym_valid}, 32'd0);
    send(1'b0);
    check("s1_valid", {31'd0, sym_valid}, 32'd1);
    check("s1_sym", {28'd0, sym}, 32'd1);
    send(1'b1);
    send(1'b1);
    check("s2_mid_valid", {31'd0, sym_valid}, 32'd0);
    send(1'b0);
    check("s2_valid", {31'd0, sym_valid}, 32'd1);
    check("s2_sym", {28'd0, sym}, 32'd2);
    send(1'b1);
    send(1'b1);
    send(1'b1);
    check("s3_valid", {31'd0, sym_valid}, 32'd1);
    check("s3_sym", {28'd0, sym}, 32'd3);
    tick();
    check("s3_drop", {31'd0, sym_valid}, 32'd0);

    // backpressure: symbol held for three stalled cycles
    sym_ready = 1'b0;
    send(1'b1);
    send(1'b1);
    send(1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", {31'd0, sym_valid}, 32'd1);
      check("bp_sym", {28'd0, sym}, 32'd2);
      check("bp_bit_ready", {31'd0, bit_ready}, 32'd0);
      tick();
    end
    sym_ready = 1'b1;
    #1;
    check("bp_last_valid", {31'd0, sym_valid}, 32'd1);
    tick();
    check("bp_single", {31'd0, sym_valid}, 32'd0);

    // table loss mid-codeword discards prefix
    send(1'b1);
    tbl_rdy = 1'b0;
    tick();
    check("abort_bit_ready", {31'd0, bit_ready}, 32'd0);
    tbl_rdy = 1'b1;
    send(1'b1);
    send(1'b0);
    check("abort_valid", {31'd0, sym_valid}, 32'd1);
    check("abort_sym", {28'd0, sym}, 32'd1);
    tick();

    // reset mid-codeword
    send(1'b1);
    send(1'b1);
    rst_n = 1'b0;
    tick();
    check("mrst_bit_ready", {31'd0, bit_ready}, 32'd0);
    check("mrst_sym_valid", {31'd0, sym_valid}, 32'd0);
    check("mrst_sym", {28'd0, sym}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    send(1'b0);
    check("mrst_valid", {31'd0, sym_valid}, 32'd1);
    check("mrst_sym0", {28'd0, sym}, 32'd0);
    tick();

    // only a length-1 code: 1111 never matches
    ccl_count_sq = 16'h0001;
    send(1'b1);
    send(1'b1);
    send(1'b1);
    send(1'b1);
    check("inv_valid", {31'd0, sym_valid}, 32'd0);
`ifdef CCL_DEC_ERR_EN
    check("inv_err", {31'd0, err}, 32'd1);
    check("inv_bit_ready", {31'd0, bit_ready}, 32'd0);
    tick();
    tick();
    check("inv_err_sticky", {31'd0, err}, 32'd1);
`else
    check("inv_err", {31'd0, err}, 32'd0);
    send(1'b0);
    check("inv_next_valid", {31'd0, sym_valid}, 32'd1);
    check("inv_next_sym", {28'd0, sym}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
